// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction-fetch sequencer for the single-cycle MIPS core.
// Optional macro PC_FETCH_CNT_EN adds the FETCH_CNT accepted-fetch counter port.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC_out,
  output logic [31:0] INC_out,
  input  logic [31:0] PC_SEQ_in,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  input  logic        JUMP,
  input  logic [31:0] J_TARGET,
  input  logic        STALL,
  input  logic        HALT,
  output logic        IM_REQ,
  input  logic        IM_ACK,
  output logic        IR_VALID,
  output logic        ALIGN_ERR
`ifdef PC_FETCH_CNT_EN
  ,
  output logic [31:0] FETCH_CNT
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        pend_valid, pend_valid_n;
  logic        pend_jump, pend_jump_n;
  logic [31:0] pend_target, pend_target_n;
  logic        ir_valid, ir_valid_n;
  logic        align_err, align_err_n;
  logic [31:0] j_aligned, br_aligned;

  assign j_aligned  = {J_TARGET[31:2], 2'b00};
  assign br_aligned = {BR_TARGET[31:2], 2'b00};

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_jump   <= 1'b0;
      pend_target <= 32'h0;
      ir_valid    <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend_valid  <= pend_valid_n;
      pend_jump   <= pend_jump_n;
      pend_target <= pend_target_n;
      ir_valid    <= ir_valid_n;
      align_err   <= align_err_n;
    end
  end

  // A stalled fetch freezes PC and pending redirect; HALT still takes effect.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pend_valid_n  = pend_valid;
    pend_jump_n   = pend_jump;
    pend_target_n = pend_target;
    ir_valid_n    = 1'b0;
    align_err_n   = 1'b0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (!STALL) begin
          if (IM_ACK) begin
            ir_valid_n   = 1'b1;
            pend_valid_n = 1'b0;
            if (JUMP) begin
              pc_n        = j_aligned;
              align_err_n = |J_TARGET[1:0];
            end else if (BR_TAKEN) begin
              pc_n        = br_aligned;
              align_err_n = |BR_TARGET[1:0];
            end else if (pend_valid) begin
              pc_n = pend_target;
            end else begin
              pc_n = PC_SEQ_in;
            end
          end else if (JUMP) begin
            pend_valid_n  = 1'b1;
            pend_jump_n   = 1'b1;
            pend_target_n = j_aligned;
            align_err_n   = |J_TARGET[1:0];
          end else if (BR_TAKEN && !(pend_valid && pend_jump)) begin
            pend_valid_n  = 1'b1;
            pend_jump_n   = 1'b0;
            pend_target_n = br_aligned;
            align_err_n   = |BR_TARGET[1:0];
          end
        end
        if (HALT) state_n = HALTED;
      end
      HALTED: state_n = HALTED;
      default: state_n = IDLE;
    endcase
  end

  assign PC_out    = pc;
  assign INC_out   = PC_INC;
  assign IM_REQ    = (state == FETCH);
  assign IR_VALID  = ir_valid;
  assign ALIGN_ERR = align_err;

`ifdef PC_FETCH_CNT_EN
  logic [31:0] fetch_cnt;

  // ir_valid_n is high exactly on an accept.
  always_ff @(posedge CLK) begin
    if (!RESET) fetch_cnt <= 32'h0;
    else if (ir_valid_n) fetch_cnt <= fetch_cnt + 32'd1;
  end

  assign FETCH_CNT = fetch_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed vectors, a behavioural
// fetch model compared every cycle, and hand-computed literal expectations.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_out, inc_out, pc_seq;
  logic        br_taken, jump, stall, halt, im_ack;
  logic [31:0] br_target, j_target;
  logic        im_req, ir_valid, align_err;
`ifdef PC_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Environment adder: PC_out + INC_out feeds back as the sequential next PC.
  assign pc_seq = pc_out + inc_out;

  pc_fetch_sequencer dut (
    .CLK(clk), .RESET(rst_n), .PC_out(pc_out), .INC_out(inc_out),
    .PC_SEQ_in(pc_seq), .BR_TAKEN(br_taken), .BR_TARGET(br_target),
    .JUMP(jump), .J_TARGET(j_target), .STALL(stall), .HALT(halt),
    .IM_REQ(im_req), .IM_ACK(im_ack), .IR_VALID(ir_valid), .ALIGN_ERR(align_err)
`ifdef PC_FETCH_CNT_EN
    , .FETCH_CNT(fetch_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the fetch rules.
  bit          m_live = 0;
  bit          m_started, m_halted;
  logic [31:0] m_pc, m_cnt;
  bit          m_pend, m_pend_is_jump;
  logic [31:0] m_pend_addr;
  bit          m_irv, m_aerr;

  always @(posedge clk) begin
    m_live = 1;
    if (!rst_n) begin
      m_pc = 32'h0; m_started = 0; m_halted = 0; m_pend = 0; m_pend_is_jump = 0;
      m_pend_addr = 32'h0; m_irv = 0; m_aerr = 0; m_cnt = 32'h0;
    end else begin
      m_irv = 0; m_aerr = 0;
      if (!m_started) m_started = 1;
      else if (!m_halted) begin
        if (!stall && im_ack) begin
          m_irv = 1;
          m_cnt = m_cnt + 1;
          if (jump) begin
            m_pc = j_target & 32'hFFFF_FFFC; m_aerr = (j_target % 4) != 0;
          end else if (br_taken) begin
            m_pc = br_target & 32'hFFFF_FFFC; m_aerr = (br_target % 4) != 0;
          end else if (m_pend) m_pc = m_pend_addr;
          else m_pc = m_pc + 32'd4;
          m_pend = 0;
        end else if (!stall) begin
          if (jump) begin
            m_pend = 1; m_pend_is_jump = 1;
            m_pend_addr = j_target & 32'hFFFF_FFFC; m_aerr = (j_target % 4) != 0;
          end else if (br_taken && !(m_pend && m_pend_is_jump)) begin
            m_pend = 1; m_pend_is_jump = 0;
            m_pend_addr = br_target & 32'hFFFF_FFFC; m_aerr = (br_target % 4) != 0;
          end
        end
        if (halt) m_halted = 1;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("INC_out", inc_out, 32'd4);
    if (m_live) begin
      checkOutput("model PC_out", pc_out, m_pc);
      checkOutput("model IM_REQ", {31'b0, im_req}, {31'b0, m_started && !m_halted});
      checkOutput("model IR_VALID", {31'b0, ir_valid}, {31'b0, m_irv});
      checkOutput("model ALIGN_ERR", {31'b0, align_err}, {31'b0, m_aerr});
`ifdef PC_FETCH_CNT_EN
      checkOutput("model FETCH_CNT", fetch_cnt, m_cnt);
`endif
    end
  end

  task automatic applyStimulus(input logic r, input logic ack, input logic st, input logic hl,
                               input logic jp, input logic [31:0] jt,
                               input logic br, input logic [31:0] bt);
    rst_n = r; im_ack = ack; stall = st; halt = hl;
    jump = jp; j_target = jt; br_taken = br; br_target = bt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; im_ack = 1; stall = 0; halt = 0;
    jump = 0; j_target = 0; br_taken = 0; br_target = 0;

    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("reset PC", pc_out, 32'h0);
    checkOutput("reset IM_REQ", {31'b0, im_req}, 32'd0);
    checkOutput("reset IR_VALID", {31'b0, ir_valid}, 32'd0);

    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("start IM_REQ", {31'b0, im_req}, 32'd1);
    checkOutput("start PC", pc_out, 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("seq PC 4", pc_out, 32'h4);
    checkOutput("seq IR_VALID", {31'b0, ir_valid}, 32'd1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("seq PC 8", pc_out, 32'h8);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
      checkOutput("stall PC", pc_out, 32'h8);
      checkOutput("stall IR_VALID", {31'b0, ir_valid}, 32'd0);
    end
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("after stall PC", pc_out, 32'hC);

    applyStimulus(1, 1, 0, 0, 1, 32'h100, 1, 32'h200);
    checkOutput("jump over branch", pc_out, 32'h100);

    applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h40);
    checkOutput("pending hold PC", pc_out, 32'h100);
    applyStimulus(1, 0, 0, 0, 1, 32'h80, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("pending jump PC", pc_out, 32'h80);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("pending cleared", pc_out, 32'h84);

    applyStimulus(1, 0, 0, 0, 1, 32'h300, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h400);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("pending jump kept", pc_out, 32'h300);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("after pending jump", pc_out, 32'h304);

    applyStimulus(1, 1, 0, 0, 1, 32'h103, 0, 0);
    checkOutput("misaligned PC", pc_out, 32'h100);
    checkOutput("ALIGN_ERR pulse", {31'b0, align_err}, 32'd1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("ALIGN_ERR clear", {31'b0, align_err}, 32'd0);
    checkOutput("after misalign PC", pc_out, 32'h104);

    applyStimulus(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    checkOutput("top PC", pc_out, 32'hFFFF_FFFC);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap PC", pc_out, 32'h0);

    applyStimulus(1, 1, 0, 0, 1, 32'h10, 0, 0);
    checkOutput("pre-halt PC", pc_out, 32'h10);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0);
    checkOutput("halt accept PC", pc_out, 32'h14);
    checkOutput("halt IR_VALID", {31'b0, ir_valid}, 32'd1);
    checkOutput("halt IM_REQ", {31'b0, im_req}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 0, 0, 1, 32'h500, 0, 0);
      checkOutput("halted PC", pc_out, 32'h14);
      checkOutput("halted IM_REQ", {31'b0, im_req}, 32'd0);
    end
`ifdef PC_FETCH_CNT_EN
    checkOutput("halted FETCH_CNT", fetch_cnt, 32'd14);
`endif

    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("halt reset PC", pc_out, 32'h0);
    checkOutput("halt reset IM_REQ", {31'b0, im_req}, 32'd0);
`ifdef PC_FETCH_CNT_EN
    checkOutput("reset FETCH_CNT", fetch_cnt, 32'd0);
`endif

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 32'h20, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 32'h40, 0, 0);
    checkOutput("mid-fetch reset PC", pc_out, 32'h0);
    checkOutput("mid-fetch reset IM_REQ", {31'b0, im_req}, 32'd0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("pending dropped", pc_out, 32'h4);

    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("halt no accept PC", pc_out, 32'h4);
    checkOutput("halt no accept IM_REQ", {31'b0, im_req}, 32'd0);
    checkOutput("halt no accept IR_VALID", {31'b0, ir_valid}, 32'd0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("halted stays", pc_out, 32'h4);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
